// File: rtl/fft_ibfly_pipe.sv
// fft_ibfly_pipe: 3-stage inverse radix-2 DIF butterfly on a valid/ready stream.
// Optional macro FFT_IBFLY_ROUND_EN: round-half-up before each right shift (default: floor).
`ifndef CFG_WN_WD
`define CFG_WN_WD 16
`endif
`ifndef DATA_FRA_WD
`define DATA_FRA_WD 14
`endif

module fft_ibfly_pipe #(
  parameter int DATA_WD = 16,
  parameter int WN_WD   = `CFG_WN_WD,
  parameter int FRA_WD  = `DATA_FRA_WD,
  parameter int SCALE   = 1,
  parameter int PAIRS   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [2*DATA_WD-1:0] dat1_i,
  input  logic [2*DATA_WD-1:0] dat2_i,
  input  logic [2*WN_WD-1:0]   wn_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [2*DATA_WD-1:0] dat1_o,
  output logic [2*DATA_WD-1:0] dat2_o,
  output logic                 out_last_o,
  output logic                 ovf_o,
  input  logic                 ovf_clr_i
);

  localparam int SW  = DATA_WD + 1;
  localparam int PW  = DATA_WD + WN_WD + 2;
  localparam int MW  = PW + 1;
  localparam int CW  = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int SH1 = SCALE;
  localparam int SH2 = FRA_WD + SCALE;

  // One spare bit above the product width keeps the rounding add from wrapping.
  function automatic logic signed [MW-1:0] shift_rnd(input logic signed [MW-1:0] x,
                                                      input int sh);
    logic signed [MW-1:0] t;
    t = x;
`ifdef FFT_IBFLY_ROUND_EN
    if (sh > 0) t = t + (MW'(1) << (sh - 1));
`endif
    return t >>> sh;
  endfunction

  function automatic logic is_sat(input logic signed [MW-1:0] x);
    return !((&x[MW-1:DATA_WD-1]) || !(|x[MW-1:DATA_WD-1]));
  endfunction

  function automatic logic [DATA_WD-1:0] sat(input logic signed [MW-1:0] x);
    if (is_sat(x))
      return x[MW-1] ? {1'b1, {(DATA_WD-1){1'b0}}} : {1'b0, {(DATA_WD-1){1'b1}}};
    return x[DATA_WD-1:0];
  endfunction

  logic                    en;
  logic                    vld_p1, vld_p2, vld_p3;
  logic signed [SW-1:0]    sr_p1, si_p1, dr_p1, di_p1;
  logic signed [WN_WD-1:0] wr_p1, wi_p1;
  logic signed [SW-1:0]    sr_p2, si_p2;
  logic signed [PW-1:0]    pr_p2, pi_p2;
  logic [CW-1:0]           cnt;

  logic signed [SW-1:0]    ar, ai, br, bi;
  logic signed [PW-1:0]    dr_x, di_x, wr_x, wi_x;
  logic signed [MW-1:0]    o1r, o1i, o2r, o2i;
  logic                    sat_any;
  logic                    ovf_set;

  assign en          = ~vld_p3 | out_ready_i;
  assign in_ready_o  = en;
  assign out_valid_o = vld_p3;
  assign out_last_o  = vld_p3 & (cnt == CW'(PAIRS - 1));

  assign ar = {dat1_i[2*DATA_WD-1], dat1_i[2*DATA_WD-1:DATA_WD]};
  assign ai = {dat1_i[DATA_WD-1],   dat1_i[DATA_WD-1:0]};
  assign br = {dat2_i[2*DATA_WD-1], dat2_i[2*DATA_WD-1:DATA_WD]};
  assign bi = {dat2_i[DATA_WD-1],   dat2_i[DATA_WD-1:0]};

  assign dr_x = {{(PW-SW){dr_p1[SW-1]}}, dr_p1};
  assign di_x = {{(PW-SW){di_p1[SW-1]}}, di_p1};
  assign wr_x = {{(PW-WN_WD){wr_p1[WN_WD-1]}}, wr_p1};
  assign wi_x = {{(PW-WN_WD){wi_p1[WN_WD-1]}}, wi_p1};

  assign o1r = shift_rnd({{(MW-SW){sr_p2[SW-1]}}, sr_p2}, SH1);
  assign o1i = shift_rnd({{(MW-SW){si_p2[SW-1]}}, si_p2}, SH1);
  assign o2r = shift_rnd({pr_p2[PW-1], pr_p2}, SH2);
  assign o2i = shift_rnd({pi_p2[PW-1], pi_p2}, SH2);

  assign sat_any = is_sat(o1r) | is_sat(o1i) | is_sat(o2r) | is_sat(o2i);
  assign ovf_set = en & vld_p2 & sat_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      sr_p1  <= '0;
      si_p1  <= '0;
      dr_p1  <= '0;
      di_p1  <= '0;
      wr_p1  <= '0;
      wi_p1  <= '0;
      sr_p2  <= '0;
      si_p2  <= '0;
      pr_p2  <= '0;
      pi_p2  <= '0;
      dat1_o <= '0;
      dat2_o <= '0;
    end else if (en) begin
      // Stage 1: sum/difference, twiddle registered alongside
      vld_p1 <= in_valid_i;
      sr_p1  <= ar + br;
      si_p1  <= ai + bi;
      dr_p1  <= ar - br;
      di_p1  <= ai - bi;
      wr_p1  <= wn_i[2*WN_WD-1:WN_WD];
      wi_p1  <= wn_i[WN_WD-1:0];
      // Stage 2: diff * conj(wn), sum delayed to stay aligned
      vld_p2 <= vld_p1;
      pr_p2  <= dr_x * wr_x + di_x * wi_x;
      pi_p2  <= di_x * wr_x - dr_x * wi_x;
      sr_p2  <= sr_p1;
      si_p2  <= si_p1;
      // Stage 3: scale, round, saturate
      vld_p3 <= vld_p2;
      dat1_o <= {sat(o1r), sat(o1i)};
      dat2_o <= {sat(o2r), sat(o2i)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (vld_p3 & out_ready_i) begin
      cnt <= (cnt == CW'(PAIRS - 1)) ? '0 : cnt + CW'(1);
    end
  end

  // Set has priority over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_o <= 1'b0;
    end else if (ovf_set) begin
      ovf_o <= 1'b1;
    end else if (ovf_clr_i) begin
      ovf_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_ibfly_pipe.sv
// Self-checking bench for fft_ibfly_pipe: scoreboard of model results, popped on output handshakes.
module tb_fft_ibfly_pipe;

  localparam int DW = 16;
  localparam int WW = 16;
  localparam int FW = 14;
  localparam int SC = 1;
  localparam int NP = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [31:0]   dat1_i, dat2_i, wn_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [31:0]   dat1_o, dat2_o;
  logic          out_last_o;
  logic          ovf_o;
  logic          ovf_clr_i;

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic        sat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   out_cnt = 0;

  always #5 clk = ~clk;

  fft_ibfly_pipe #(.DATA_WD(DW), .WN_WD(WW), .FRA_WD(FW), .SCALE(SC), .PAIRS(NP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .dat1_i(dat1_i), .dat2_i(dat2_i), .wn_i(wn_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .dat1_o(dat1_o), .dat2_o(dat2_o), .out_last_o(out_last_o),
    .ovf_o(ovf_o), .ovf_clr_i(ovf_clr_i)
  );

  function automatic longint shr(input longint x, input int sh);
    longint t;
    t = x;
`ifdef FFT_IBFLY_ROUND_EN
    if (sh > 0) t = t + (longint'(1) << (sh - 1));
`endif
    return t >>> sh;
  endfunction

  function automatic logic over(input longint x);
    return (x > 32767) || (x < -32768);
  endfunction

  function automatic logic [15:0] clamp(input longint x);
    if (x > 32767) return 16'h7FFF;
    if (x < -32768) return 16'h8000;
    return x[15:0];
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] w);
    longint ar, ai, br, bi, wr, wi, dr, di, s1r, s1i, s2r, s2i;
    exp_t e;
    ar = longint'($signed(a[31:16])); ai = longint'($signed(a[15:0]));
    br = longint'($signed(b[31:16])); bi = longint'($signed(b[15:0]));
    wr = longint'($signed(w[31:16])); wi = longint'($signed(w[15:0]));
    dr = ar - br;
    di = ai - bi;
    s1r = shr(ar + br, SC);
    s1i = shr(ai + bi, SC);
    s2r = shr(dr * wr + di * wi, FW + SC);
    s2i = shr(di * wr - dr * wi, FW + SC);
    e.d1  = {clamp(s1r), clamp(s1i)};
    e.d2  = {clamp(s2r), clamp(s2i)};
    e.sat = over(s1r) | over(s1i) | over(s2r) | over(s2i);
    return e;
  endfunction

  // Drives one cycle of stimulus; reports accept/handshake and queues the model result.
  task automatic cycle(input logic iv, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] w, input logic ordy,
                       output logic acc, output logic hs);
    @(negedge clk);
    in_valid_i = iv; dat1_i = a; dat2_i = b; wn_i = w; out_ready_i = ordy;
    #1;
    acc = iv & in_ready_o;
    hs  = out_valid_o & ordy;
    if (acc) exp_q.push_back(model(a, b, w));
  endtask

  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic [31:0] w,
                         output logic found, output int lat,
                         output logic [31:0] d1, output logic [31:0] d2, output exp_t e);
    logic acc, hs;
    found = 1'b0; lat = 0; d1 = '0; d2 = '0;
    e = '{d1: '0, d2: '0, sat: 1'b0};
    cycle(1'b1, a, b, w, 1'b1, acc, hs);
    for (int i = 1; i <= 10 && !found; i++) begin
      cycle(1'b0, '0, '0, '0, 1'b1, acc, hs);
      if (hs) begin
        found = 1'b1; lat = i; d1 = dat1_o; d2 = dat2_o;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        out_cnt++;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; ovf_clr_i = 1'b0;
    dat1_i = '0; dat2_i = '0; wn_i = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({out_valid_o, out_last_o, ovf_o, in_ready_o, dat1_o, dat2_o} !== {4'b0001, 64'h0}) begin
      errors++;
      $display("FAIL reset_state got v%b l%b o%b r%b %h %h want v0 l0 o0 r1 0 0",
               out_valid_o, out_last_o, ovf_o, in_ready_o, dat1_o, dat2_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    out_cnt = 0;
  endtask

  task automatic test_identity;
    logic found; int lat; logic [31:0] d1, d2; exp_t e;
    run_one({16'd100, 16'd50}, {16'd20, 16'd10}, {16'd16384, 16'd0}, found, lat, d1, d2, e);
    checks++;
    if (!found || lat != 3) begin
      errors++; $display("FAIL ident_latency got found=%b lat=%0d want found=1 lat=3", found, lat);
    end
    checks++;
    if (d1 !== {16'd60, 16'd30}) begin
      errors++; $display("FAIL ident_dat1 got %h want %h", d1, {16'd60, 16'd30});
    end
    checks++;
    if (d2 !== {16'd40, 16'd20}) begin
      errors++; $display("FAIL ident_dat2 got %h want %h", d2, {16'd40, 16'd20});
    end
  endtask

  task automatic test_conj;
    logic found; int lat; logic [31:0] d1, d2; exp_t e;
    run_one({16'd100, 16'd50}, {16'd20, 16'd10}, {16'h0000, 16'hC000}, found, lat, d1, d2, e);
    checks++;
    if (!found || d2 !== {16'hFFEC, 16'h0028} || d1 !== {16'd60, 16'd30}) begin
      errors++; $display("FAIL conj_dat got found=%b %h %h want %h %h", found, d1, d2,
                         {16'd60, 16'd30}, {16'hFFEC, 16'h0028});
    end
  endtask

  task automatic test_round;
    logic found; int lat; logic [31:0] d1, d2, want; exp_t e;
`ifdef FFT_IBFLY_ROUND_EN
    want = {16'h0002, 16'hFFFF};
`else
    want = {16'h0001, 16'hFFFE};
`endif
    run_one({16'h0003, 16'hFFFD}, 32'h0, {16'd16384, 16'd0}, found, lat, d1, d2, e);
    checks++;
    if (!found || d1 !== want) begin
      errors++; $display("FAIL round_dat1 got found=%b %h want %h", found, d1, want);
    end
    checks++;
    if (d2 !== want) begin
      errors++; $display("FAIL round_dat2 got %h want %h", d2, want);
    end
  endtask

  task automatic test_saturation;
    logic found; int lat; logic [31:0] d1, d2; exp_t e;
    run_one({16'h7FFF, 16'h0000}, {16'h8000, 16'h0000}, {16'h7FFF, 16'h0000}, found, lat, d1, d2, e);
    checks++;
    if (!found || d2 !== {16'h7FFF, 16'h0000} || d1 !== e.d1) begin
      errors++; $display("FAIL sat_pos got %h %h want %h %h", d1, d2, e.d1, {16'h7FFF, 16'h0000});
    end
    checks++;
    if (ovf_o !== 1'b1) begin
      errors++; $display("FAIL sat_ovf_set got %b want 1", ovf_o);
    end
    @(negedge clk); ovf_clr_i = 1'b1;
    @(negedge clk); ovf_clr_i = 1'b0;
    #1;
    checks++;
    if (ovf_o !== 1'b0) begin
      errors++; $display("FAIL sat_ovf_clr got %b want 0", ovf_o);
    end
    run_one({16'h8000, 16'h0000}, {16'h7FFF, 16'h0000}, {16'h7FFF, 16'h0000}, found, lat, d1, d2, e);
    checks++;
    if (!found || d2 !== {16'h8000, 16'h0000} || ovf_o !== 1'b1) begin
      errors++; $display("FAIL sat_neg got %h ovf=%b want %h ovf=1", d2, ovf_o, {16'h8000, 16'h0000});
    end
    @(negedge clk); ovf_clr_i = 1'b1;
    @(negedge clk); ovf_clr_i = 1'b0;
  endtask

  task automatic test_backpressure;
    logic acc, hs, ordy;
    logic [31:0] held;
    int sent, got;
    exp_t e;
    sent = 0; got = 0; held = '0;
    for (int c = 1; c <= 40 && got < 5; c++) begin
      ordy = !(c >= 4 && c <= 6);
      cycle(sent < 5, {16'(100 * (sent + 1)), 16'(sent + 1)}, {16'(sent + 7), 16'd3},
            {16'd16384, 16'd0}, ordy, acc, hs);
      if (acc) sent++;
      if (c == 4) held = dat2_o;
      if (c >= 4 && c <= 6) begin
        checks++;
        if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0 || dat2_o !== held) begin
          errors++; $display("FAIL bp_stall c=%0d got v%b r%b %h want v1 r0 %h",
                             c, out_valid_o, in_ready_o, dat2_o, held);
        end
      end
      if (hs) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra got output %h want none", dat1_o);
        end else begin
          e = exp_q.pop_front();
          if ({dat1_o, dat2_o} !== {e.d1, e.d2}) begin
            errors++; $display("FAIL bp_data idx=%0d got %h %h want %h %h", got, dat1_o, dat2_o, e.d1, e.d2);
          end
        end
        got++; out_cnt++;
      end
    end
    checks++;
    if (got != 5 || exp_q.size() != 0) begin
      errors++; $display("FAIL bp_count got %0d left %0d want 5 left 0", got, exp_q.size());
    end
  endtask

  task automatic test_last;
    logic acc, hs, want_last;
    int sent, got;
    exp_t e;
    sent = 0; got = 0;
    for (int c = 0; c < 100 && got < 33; c++) begin
      cycle(sent < 33, {16'(sent * 3), 16'(-sent)}, {16'(sent), 16'd5}, {16'd11585, 16'd11585},
            1'b1, acc, hs);
      if (acc) sent++;
      if (hs) begin
        want_last = (got == 31);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '{d1: 32'hx, d2: 32'hx, sat: 1'b0};
        checks++;
        if (out_last_o !== want_last || {dat1_o, dat2_o} !== {e.d1, e.d2}) begin
          errors++; $display("FAIL last_out idx=%0d got last=%b %h %h want last=%b %h %h",
                             got, out_last_o, dat1_o, dat2_o, want_last, e.d1, e.d2);
        end
        got++; out_cnt++;
      end
    end
    checks++;
    if (got != 33) begin
      errors++; $display("FAIL last_count got %0d want 33", got);
    end
  endtask

  task automatic test_back_to_back;
    logic acc, hs, want_last;
    int sent, got;
    exp_t e;
    sent = 0; got = 0;
    for (int c = 0; c < 400 && got < 40; c++) begin
      cycle(sent < 40, $urandom, $urandom, $urandom, $urandom_range(0, 3) != 0, acc, hs);
      if (acc) sent++;
      if (hs) begin
        want_last = ((out_cnt % NP) == NP - 1);
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra got output %h want none", dat1_o);
        end else begin
          e = exp_q.pop_front();
          if ({dat1_o, dat2_o} !== {e.d1, e.d2} || out_last_o !== want_last ||
              (e.sat && ovf_o !== 1'b1)) begin
            errors++; $display("FAIL b2b_data idx=%0d got %h %h l%b o%b want %h %h l%b sat%b",
                               got, dat1_o, dat2_o, out_last_o, ovf_o, e.d1, e.d2, want_last, e.sat);
          end
        end
        got++; out_cnt++;
      end
    end
    checks++;
    if (got != 40) begin
      errors++; $display("FAIL b2b_count got %0d want 40", got);
    end
  endtask

  task automatic test_reset_midflight;
    logic acc, hs;
    int seen;
    seen = 0;
    cycle(1'b1, {16'd8, 16'd8}, {16'd2, 16'd2}, {16'd16384, 16'd0}, 1'b0, acc, hs);
    cycle(1'b1, {16'd9, 16'd9}, {16'd1, 16'd1}, {16'd16384, 16'd0}, 1'b0, acc, hs);
    cycle(1'b0, '0, '0, '0, 1'b0, acc, hs);
    cycle(1'b0, '0, '0, '0, 1'b0, acc, hs);
    checks++;
    if (out_valid_o !== 1'b1) begin
      errors++; $display("FAIL rst_pre_valid got %b want 1", out_valid_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || dat1_o !== 32'h0 || out_last_o !== 1'b0) begin
      errors++; $display("FAIL rst_async got v%b %h l%b want v0 0 l0", out_valid_o, dat1_o, out_last_o);
    end
    @(negedge clk); rst_n = 1'b1;
    exp_q.delete(); out_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0, '0, '0, '0, 1'b1, acc, hs);
      if (out_valid_o) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL rst_no_output got %0d valid cycles want 0", seen);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_identity();
    test_conj();
    test_round();
    test_saturation();
    test_backpressure();
    test_reset();
    test_last();
    test_back_to_back();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
